buzzer_arbiter: RTL and testbench



---
 rtl/buzzer_pkg.sv | 32 +++
 rtl/tone_gen.sv | 34 +++
 rtl/buzzer_arbiter.sv | 150 +++++++++++++++
 tb/tb_buzzer_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared tone ids, FSM encodings, default tone timing and the fixed-priority picker
// for the buzzer arbiter.
package buzzer_pkg;

  localparam logic [1:0] TONE_KEY = 2'd0;
  localparam logic [1:0] TONE_OK  = 2'd1;
  localparam logic [1:0] TONE_ERR = 2'd2;
  localparam logic [1:0] TONE_ALM = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_TONE, ST_GAP} state_t;
  typedef enum logic [2:0] {ACT_HOLD, ACT_START, ACT_STOP, ACT_END, ACT_GAP, ACT_BEEP2} act_t;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_KEY_HALF = 50000;
  localparam int DEF_KEY_LEN  = 10000000;
  localparam int DEF_OK_HALF  = 10000;
  localparam int DEF_OK_LEN   = 50000000;
  localparam int DEF_ERR_HALF = 25000;
  localparam int DEF_ERR_BEEP = 12500000;
  localparam int DEF_ALM_HALF = 5000;

  // Bit index is the tone id, so the highest set bit wins.
  function automatic logic [1:0] prio_pick(input logic [3:0] req);
    logic [1:0] id;
    id = TONE_KEY;
    if (req[3])      id = TONE_ALM;
    else if (req[2]) id = TONE_ERR;
    else if (req[1]) id = TONE_OK;
    return id;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: output toggles every `half` enabled cycles.
// A clear restarts the half-period and loads the output level with clr_val.
module tone_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             clr_val,
  input  logic [CNT_W-1:0] half,
  output logic             tone
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tone <= clr_val;
    end else if (en) begin
      if (cnt >= half - CNT_W'(1)) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, preemptive arbiter sharing one piezo pin between four tone sources,
// with per-source one-deep pending latches. Optional BUZZER_MUTE_EN adds a mute input.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int KEY_HALF = DEF_KEY_HALF,
  parameter int KEY_LEN  = DEF_KEY_LEN,
  parameter int OK_HALF  = DEF_OK_HALF,
  parameter int OK_LEN   = DEF_OK_LEN,
  parameter int ERR_HALF = DEF_ERR_HALF,
  parameter int ERR_BEEP = DEF_ERR_BEEP,
  parameter int ALM_HALF = DEF_ALM_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_req,
  input  logic       ok_req,
  input  logic       err_req,
  input  logic       lock_req,
`ifdef BUZZER_MUTE_EN
  input  logic       mute,
`endif
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  state_t           state;
  act_t             act;
  logic [CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0] half_sel;
  logic [CNT_W-1:0] len_sel;
  logic             beep;
  logic             dur_done;
  logic [2:0]       pend;
  logic [2:0]       pend_nxt;
  logic [3:0]       req;
  logic [3:0]       cand;
  logic [3:0]       win_oh;
  logic [1:0]       top_id;
  logic [1:0]       win_id;
  logic             tone;
  logic             tg_clr;
  logic             tg_load;
  logic             tg_en;

  always_comb begin
    req    = {lock_req, err_req, ok_req, key_req};
    cand   = req | {1'b0, pend};
    top_id = prio_pick(req);
    win_id = (state == ST_IDLE) ? prio_pick(cand) : top_id;
    win_oh = 4'b0001 << win_id;

    case (active_id)
      TONE_KEY: begin half_sel = CNT_W'(KEY_HALF); len_sel = CNT_W'(KEY_LEN);  end
      TONE_OK:  begin half_sel = CNT_W'(OK_HALF);  len_sel = CNT_W'(OK_LEN);   end
      TONE_ERR: begin half_sel = CNT_W'(ERR_HALF); len_sel = CNT_W'(ERR_BEEP); end
      default:  begin half_sel = CNT_W'(ALM_HALF); len_sel = '1;               end
    endcase
    dur_done = dur_cnt >= len_sel - CNT_W'(1);

    act = ACT_HOLD;
    if (state == ST_IDLE) begin
      if (|cand) act = ACT_START;
    end else if (active_id == TONE_ALM) begin
      // Alarm has no duration; it tracks the lock_req level only.
      if (!lock_req) act = ACT_STOP;
    end else if (|req && top_id >= active_id) begin
      act = ACT_START;
    end else if (dur_done) begin
      if (state == ST_GAP)                        act = ACT_BEEP2;
      else if (active_id == TONE_ERR && !beep)    act = ACT_GAP;
      else                                        act = ACT_END;
    end

    pend_nxt = pend | req[2:0];
    if (act == ACT_START) pend_nxt = pend_nxt & ~win_oh[2:0];
    if (lock_req)         pend_nxt = '0;

    tg_clr  = (act != ACT_HOLD);
    tg_load = (act == ACT_START) || (act == ACT_BEEP2);
    tg_en   = (state == ST_TONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      active_id <= TONE_KEY;
      busy      <= 1'b0;
      done      <= 1'b0;
      dur_cnt   <= '0;
      beep      <= 1'b0;
      pend      <= '0;
    end else begin
      done <= 1'b0;
      pend <= pend_nxt;
      case (act)
        ACT_START: begin
          state     <= ST_TONE;
          active_id <= win_id;
          busy      <= 1'b1;
          dur_cnt   <= '0;
          beep      <= 1'b0;
        end
        ACT_STOP: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          dur_cnt <= '0;
        end
        ACT_END: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          dur_cnt <= '0;
          done    <= 1'b1;
        end
        ACT_GAP: begin
          state   <= ST_GAP;
          dur_cnt <= '0;
        end
        ACT_BEEP2: begin
          state   <= ST_TONE;
          dur_cnt <= '0;
          beep    <= 1'b1;
        end
        default: begin
          if (state != ST_IDLE) dur_cnt <= dur_cnt + CNT_W'(1);
        end
      endcase
    end
  end

  tone_gen #(.CNT_W(CNT_W)) u_tone_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tg_en),
    .clr     (tg_clr),
    .clr_val (tg_load),
    .half    (half_sel),
    .tone    (tone)
  );

`ifdef BUZZER_MUTE_EN
  assign buzzer = tone & ~mute;
`else
  assign buzzer = tone;
`endif

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Randomized and directed bench for buzzer_arbiter against a tone-timeline reference model.
module tb_buzzer_arbiter;

  localparam int KH = 2;
  localparam int KL = 20;
  localparam int OH = 3;
  localparam int OL = 30;
  localparam int EH = 2;
  localparam int EB = 8;
  localparam int AH = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_req = 1'b0;
  logic       ok_req = 1'b0;
  logic       err_req = 1'b0;
  logic       lock_req = 1'b0;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Reference state: current tone (-1 idle), cycles since it started, pending set, done pulse.
  int       m_id = -1;
  int       m_t = 0;
  bit [2:0] m_pend = '0;
  bit       m_done = 1'b0;

  buzzer_arbiter #(
    .CNT_W(32), .KEY_HALF(KH), .KEY_LEN(KL), .OK_HALF(OH), .OK_LEN(OL),
    .ERR_HALF(EH), .ERR_BEEP(EB), .ALM_HALF(AH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_req(key_req), .ok_req(ok_req), .err_req(err_req),
    .lock_req(lock_req), .buzzer(buzzer), .busy(busy), .active_id(active_id), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int highest(input bit [3:0] v);
    int h;
    h = -1;
    for (int i = 0; i < 4; i++) if (v[i]) h = i;
    return h;
  endfunction

  function automatic int total_len(input int id);
    case (id)
      0:       return KL;
      1:       return OL;
      2:       return 3 * EB;
      default: return 0;
    endcase
  endfunction

  // Pin level as a function of position in the tone's timeline.
  function automatic bit exp_buzzer(input int id, input int t);
    case (id)
      0:  return ((t / KH) % 2) == 0;
      1:  return ((t / OH) % 2) == 0;
      2: begin
        if (t < EB)          return ((t / EH) % 2) == 0;
        else if (t < 2 * EB) return 1'b0;
        else                 return (((t - 2 * EB) / EH) % 2) == 0;
      end
      3:  return ((t / AH) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_id = -1;
    m_t = 0;
    m_pend = '0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit k, input bit o, input bit e, input bit l);
    bit [3:0] r;
    int w;
    bit started;
    r = {l, e, o, k};
    w = -1;
    started = 1'b0;
    m_done = 1'b0;
    if (m_id < 0) begin
      if ((r | {1'b0, m_pend}) != 0) begin
        w = highest(r | {1'b0, m_pend});
        started = 1'b1;
      end
    end else if (m_id == 3) begin
      if (!l) m_id = -1;
      else    m_t++;
    end else if (r != 0 && highest(r) >= m_id) begin
      w = highest(r);
      started = 1'b1;
    end else if (m_t == total_len(m_id) - 1) begin
      m_id = -1;
      m_done = 1'b1;
    end else begin
      m_t++;
    end
    m_pend = m_pend | r[2:0];
    if (started) begin
      m_id = w;
      m_t = 0;
      if (w < 3) m_pend[w] = 1'b0;
    end
    if (l) m_pend = '0;
  endtask

  // One clock: compare outputs on the falling edge, then drive next inputs.
  task automatic cycle(input bit k, input bit o, input bit e, input bit l);
    @(negedge clk);
    check("busy", {31'd0, busy}, {31'd0, m_id >= 0});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("buzzer", {31'd0, buzzer}, {31'd0, (m_id >= 0) ? exp_buzzer(m_id, m_t) : 1'b0});
    if (m_id >= 0) check("active_id", {30'd0, active_id}, m_id);
    key_req = k;
    ok_req = o;
    err_req = e;
    lock_req = l;
    model_step(k, o, e, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_buzzer"}, {31'd0, buzzer}, 32'd0);
    check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check({pfx, "_active_id"}, {30'd0, active_id}, 32'd0);
    check({pfx, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lock_left;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // Lone key click, then lone wrong-code cadence.
    cycle(1, 0, 0, 0); idle(25);
    cycle(0, 0, 1, 0); idle(30);
    // ok playing, key pended at cycle 5, key follows ok's done.
    cycle(0, 1, 0, 0); idle(4); cycle(1, 0, 0, 0); idle(40);
    // key preempted by err at cycle 4, never resumed.
    cycle(1, 0, 0, 0); idle(3); cycle(0, 0, 1, 0); idle(30);
    // Alarm during ok with key pended.
    cycle(0, 1, 0, 0); idle(2); cycle(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) cycle(0, 0, 0, 1);
    idle(40);
    // Same-class retrigger and simultaneous requests.
    cycle(1, 0, 0, 0); idle(5); cycle(1, 0, 0, 0); idle(25);
    cycle(1, 1, 1, 0); idle(70);

    // Asynchronous reset in the middle of the err gap.
    cycle(0, 0, 1, 0); idle(12);
    check("gap_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    lock_left = 0;
    for (int i = 0; i < 4000; i++) begin
      bit l;
      if (lock_left == 0 && $urandom_range(0, 299) == 0) lock_left = $urandom_range(1, 40);
      l = (lock_left > 0);
      if (lock_left > 0) lock_left--;
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 59) == 0, l);
    end
    idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
